// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles SYNC/CMD/OPERAND/CHK frames from the UART byte
// stream, executes them, drives the LEDs and queues one response byte per frame.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [3:0] leds,
    output logic [7:0] err_count,
    output logic       frame_ok
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_OPR,
        S_CHK,
        S_EXEC,
        S_SEND
    } state_t;

    state_t        state_q;
    logic          valid_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    cmd_q;
    logic [7:0]    opr_q;
    logic [7:0]    chk_q;
    logic [3:0]    leds_q;
    logic [7:0]    tx_data_q;
    logic          tx_start_q;
    logic [7:0]    err_q;
    logic          frame_ok_q;

    logic          accept;
    logic          in_get;
    logic          timeout;
    logic          overrun;
    logic          nak;
    logic [7:0]    resp_d;
    logic          resp_ok_d;
    logic          set_leds_d;
    logic [7:0]    err_d;

    // Rising edge of rx_valid marks one new byte, however long it is held.
    assign accept = rx_valid && !valid_q;

    // Frame checking and command decode, plus the merged error increment.
    always_comb begin
        resp_d     = NAK;
        resp_ok_d  = 1'b0;
        set_leds_d = 1'b0;
        if (chk_q == (cmd_q ^ opr_q)) begin
            unique case (cmd_q)
                8'h01: begin
                    resp_d     = ACK;
                    resp_ok_d  = 1'b1;
                    set_leds_d = 1'b1;
                end
                8'h02: begin
                    resp_d    = opr_q + 8'd1;
                    resp_ok_d = 1'b1;
                end
                8'h03: begin
                    resp_d    = {4'b0000, leds_q};
                    resp_ok_d = 1'b1;
                end
                default: begin
                    resp_d    = NAK;
                    resp_ok_d = 1'b0;
                end
            endcase
        end

        in_get  = (state_q == S_CMD) || (state_q == S_OPR)
               || (state_q == S_CHK);
        timeout = in_get && !accept && (cnt_q == TO_LAST);
        overrun = accept && ((state_q == S_EXEC) || (state_q == S_SEND));
        nak     = (state_q == S_EXEC) && !resp_ok_d;

        err_d = err_q;
        if ((timeout || overrun || nak) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // Frame FSM with registered outputs; counter runs only while collecting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            cmd_q      <= 8'h00;
            opr_q      <= 8'h00;
            chk_q      <= 8'h00;
            leds_q     <= 4'h0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            err_q      <= 8'h00;
            frame_ok_q <= 1'b0;
        end else begin
            valid_q    <= rx_valid;
            tx_start_q <= 1'b0;
            frame_ok_q <= 1'b0;
            err_q      <= err_d;

            if (in_get && !accept && !timeout) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (accept && (rx_data == SYNC_BYTE)) begin
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (accept) begin
                        cmd_q   <= rx_data;
                        state_q <= S_OPR;
                    end else if (timeout) begin
                        state_q <= S_IDLE;
                    end
                end
                S_OPR: begin
                    if (accept) begin
                        opr_q   <= rx_data;
                        state_q <= S_CHK;
                    end else if (timeout) begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        chk_q   <= rx_data;
                        state_q <= S_EXEC;
                    end else if (timeout) begin
                        state_q <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    tx_data_q  <= resp_d;
                    frame_ok_q <= resp_ok_d;
                    if (set_leds_d) begin
                        leds_q <= opr_q[3:0];
                    end
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign leds      = leds_q;
    assign err_count = err_q;
    assign frame_ok  = frame_ok_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frames checked against a
// frame-level reference model of the command parser.
module tb_uart_cmd_parser;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [3:0] leds;
    logic [7:0] err_count;
    logic       frame_ok;

    uart_cmd_parser #(
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .tx_busy(tx_busy),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .leds(leds),
        .err_count(err_count),
        .frame_ok(frame_ok)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [3:0] m_leds = 4'h0;
    int         m_err = 0;

    // Monitor
    int         pcyc = 0;
    int         fo_cnt = 0;
    int         last_acc = 0;
    logic [7:0] tx_q[$];
    int         txc_q[$];

    always @(posedge clk) pcyc++;

    always @(negedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            txc_q.push_back(pcyc);
        end
        if (frame_ok) fo_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void m_bump();
        if (m_err < 255) m_err++;
    endfunction

    function automatic logic [7:0] m_exec(input logic [7:0] c,
                                          input logic [7:0] o,
                                          input logic [7:0] k,
                                          output bit ok);
        logic [7:0] r;
        ok = 1'b0;
        r  = 8'h15;
        if (k != (c ^ o)) begin
            m_bump();
        end else if (c == 8'h01) begin
            m_leds = o[3:0];
            r  = 8'h06;
            ok = 1'b1;
        end else if (c == 8'h02) begin
            r  = 8'((int'(o) + 1) % 256);
            ok = 1'b1;
        end else if (c == 8'h03) begin
            r  = {4'h0, m_leds};
            ok = 1'b1;
        end else begin
            m_bump();
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pause(input int g);
        repeat (g) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        tick();
        rx_data  = b;
        rx_valid = 1'b1;
        last_acc = pcyc + 1;
        repeat (hold) tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_at(input logic [7:0] b, input int edge_n);
        int guard;
        guard = 0;
        while (pcyc < edge_n - 1 && guard < 1000) begin
            tick();
            guard++;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        last_acc = pcyc + 1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(output bit got, output logic [7:0] d,
                           output int c);
        got = 1'b0;
        d   = 8'h00;
        c   = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (tx_q.size() > 0) begin
                got = 1'b1;
                d   = tx_q.pop_front();
                c   = txc_q.pop_front();
            end else begin
                tick();
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [7:0] o,
                             input logic [7:0] k, input int hold,
                             input int gap, input bit lead);
        int         fo0, n, tc;
        bit         got, ok;
        logic [7:0] d, e;
        fo0 = fo_cnt;
        if (lead) begin
            send_byte(8'hA5, hold);
            pause(gap);
            send_byte(c, hold);
            pause(gap);
        end
        send_byte(o, hold);
        pause(gap);
        send_byte(k, hold);
        n = last_acc;
        e = m_exec(c, o, k, ok);
        wait_tx(got, d, tc);
        check("tx_seen", 32'(got), 32'd1);
        check("tx_data", 32'(d), 32'(e));
        check("tx_latency", 32'(tc - n), 32'd2);
        check("frame_ok", 32'(fo_cnt - fo0), 32'(ok));
        check("leds", 32'(leds), 32'(m_leds));
        check("err_count", 32'(err_count), 32'(m_err));
        pause(2);
        check("single_tx", 32'(tx_q.size()), 32'd0);
    endtask

    task automatic reset_pulse();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n  = 1'b1;
        m_leds = 4'h0;
        m_err  = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         e0, fo0, n, tc, rel;
        bit         got, ok;
        logic [7:0] d, e, c, o, k, b;

        // Reset state
        pause(3);
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        rst_n = 1'b1;
        pause(2);

        // Directed frames
        run_frame(8'h01, 8'h05, 8'h04, 3, 1, 1'b1);
        run_frame(8'h02, 8'hFF, 8'hFD, 2, 0, 1'b1);
        run_frame(8'h03, 8'h00, 8'h03, 1, 2, 1'b1);
        run_frame(8'h01, 8'h05, 8'h00, 1, 0, 1'b1);
        run_frame(8'h07, 8'h00, 8'h07, 2, 1, 1'b1);

        // Transmitter busy, overrun byte during SEND
        tick();
        tx_busy = 1'b1;
        fo0 = fo_cnt;
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h03, 1);
        send_byte(8'h02, 1);
        e = m_exec(8'h01, 8'h03, 8'h02, ok);
        pause(10);
        send_byte(8'hA5, 1);
        m_bump();
        pause(38);
        check("busy_no_tx", 32'(tx_q.size()), 32'd0);
        check("busy_overrun_err", 32'(err_count), 32'(m_err));
        check("busy_leds", 32'(leds), 32'(m_leds));
        tx_busy = 1'b0;
        rel = pcyc + 1;
        wait_tx(got, d, tc);
        check("busy_tx_seen", 32'(got), 32'd1);
        check("busy_tx_data", 32'(d), 32'(e));
        check("busy_release", 32'(tc), 32'(rel));
        check("busy_frame_ok", 32'(fo_cnt - fo0), 32'(ok));
        send_byte(8'h01, 1);
        send_byte(8'h05, 1);
        send_byte(8'h04, 1);
        pause(10);
        check("no_resync_tx", 32'(tx_q.size()), 32'd0);
        check("no_resync_err", 32'(err_count), 32'(m_err));

        // Timeout after SYNC,CMD
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        pause(20);
        m_bump();
        check("timeout_err", 32'(err_count), 32'(m_err));
        check("timeout_no_tx", 32'(tx_q.size()), 32'd0);
        run_frame(8'h01, 8'h0A, 8'h0B, 1, 1, 1'b1);

        // Timeout boundary: byte on the terminal cycle wins
        send_byte(8'hA5, 1);
        e0 = last_acc;
        send_at(8'h01, e0 + TO);
        check("term_byte_err", 32'(err_count), 32'(m_err));
        run_frame(8'h01, 8'h06, 8'h07, 1, 0, 1'b0);

        // Timeout boundary: one cycle later expires
        send_byte(8'hA5, 1);
        e0 = last_acc;
        while (pcyc < e0 + TO - 1) tick();
        check("pre_timeout_err", 32'(err_count), 32'(m_err));
        tick();
        m_bump();
        check("at_timeout_err", 32'(err_count), 32'(m_err));
        send_byte(8'h01, 1);
        send_byte(8'h05, 1);
        send_byte(8'h04, 1);
        pause(10);
        check("after_timeout_tx", 32'(tx_q.size()), 32'd0);

        // Stray bytes before SYNC
        send_byte(8'h00, 2);
        send_byte(8'hFF, 1);
        pause(5);
        check("stray_err", 32'(err_count), 32'(m_err));
        check("stray_tx", 32'(tx_q.size()), 32'd0);
        run_frame(8'h03, 8'h00, 8'h03, 1, 0, 1'b1);

        // Reset mid-frame
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        reset_pulse();
        check("mrst_leds", 32'(leds), 32'd0);
        check("mrst_err", 32'(err_count), 32'd0);
        check("mrst_tx_data", 32'(tx_data), 32'd0);
        check("mrst_tx_start", 32'(tx_start), 32'd0);
        check("mrst_frame_ok", 32'(frame_ok), 32'd0);
        send_byte(8'h05, 1);
        send_byte(8'h04, 1);
        pause(10);
        check("mrst_no_tx", 32'(tx_q.size()), 32'd0);

        // Reset mid-SEND
        tick();
        tx_busy = 1'b1;
        send_byte(8'hA5, 1);
        send_byte(8'h01, 1);
        send_byte(8'h0C, 1);
        send_byte(8'h0D, 1);
        pause(5);
        reset_pulse();
        tx_busy = 1'b0;
        pause(10);
        check("srst_no_tx", 32'(tx_q.size()), 32'd0);
        check("srst_leds", 32'(leds), 32'd0);
        check("srst_err", 32'(err_count), 32'd0);

        // Randomized frames
        for (int i = 0; i < 60; i++) begin
            for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, int'($urandom_range(1, 3)));
            end
            case ($urandom_range(0, 3))
                0: c = 8'h01;
                1: c = 8'h02;
                2: c = 8'h03;
                default: c = 8'($urandom);
            endcase
            o = 8'($urandom);
            k = c ^ o;
            if ($urandom_range(0, 3) == 0) k = k ^ 8'($urandom_range(1, 255));
            run_frame(c, o, k, int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 3)), 1'b1);
        end

        // Error counter saturation
        while (m_err < 258 && err_count != 8'hFF) begin
            run_frame(8'h01, 8'h00, 8'h55, 1, 0, 1'b1);
        end
        run_frame(8'h01, 8'h00, 8'h55, 1, 0, 1'b1);
        run_frame(8'h09, 8'h00, 8'h09, 1, 0, 1'b1);
        check("err_saturated", 32'(err_count), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Framed command parser between the UART receiver and transmitter in the FPGA top level.
- Consumes the byte stream from the UART receiver and assembles 4-byte frames: SYNC, CMD, OPERAND, CHK.
- Executes each frame and drives the board LEDs.
- Queues one response byte per frame to the UART transmitter.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 100000, max clk cycles allowed between bytes inside a frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- rx_data  input  8  byte from UART receiver; valid while rx_valid high
- rx_valid  input  1  receiver data-valid; level, may stay high several cycles
- tx_busy  input  1  transmitter busy
- tx_data  output  8  response byte to transmitter
- tx_start  output  1  one-cycle transmit request
- leds  output  4  LED register
- err_count  output  8  saturating error counter
- frame_ok  output  1  one-cycle pulse per correctly executed frame

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-low: all state updates on posedge clk when rst_n=0.
  - Reset values: leds=0, tx_data=0, tx_start=0, err_count=0, frame_ok=0, state=IDLE, valid_d=0, timeout counter=0.
- Byte acceptance:
  - A byte is accepted on a cycle where rx_valid=1 and valid_d=0 (rising edge); rx_data is sampled that cycle.
  - valid_d <= rx_valid every cycle.
  - Holding rx_valid high yields exactly one byte.
- FSM states: IDLE, GET_CMD, GET_OPR, GET_CHK, EXEC, SEND.
  - IDLE: accepted byte == SYNC_BYTE -> GET_CMD. Any other byte is discarded silently.
  - GET_CMD: accepted byte -> cmd register -> GET_OPR. A second SYNC_BYTE here is taken as cmd; no resync.
  - GET_OPR: accepted byte -> opr register -> GET_CHK.
  - GET_CHK: accepted byte -> chk register -> EXEC.
  - EXEC (one cycle): check and execute (see below) -> SEND.
  - SEND: when tx_busy=0, assert tx_start for exactly one cycle -> IDLE. While tx_busy=1, wait with tx_start=0.
- EXEC rules:
  - chk != cmd ^ opr: tx_data=8'h15 (NAK), err_count+1, leds unchanged, no frame_ok.
  - cmd=8'h01 (SET_LEDS): leds<=opr[3:0], tx_data=8'h06 (ACK).
  - cmd=8'h02 (ECHO_INC): tx_data=opr+1, modulo 256 (8'hFF -> 8'h00).
  - cmd=8'h03 (READ_LEDS): tx_data={4'b0, leds}, using leds before this frame.
  - Any other cmd: tx_data=8'h15, err_count+1.
  - frame_ok pulses in the EXEC cycle only for a valid checksum and a known cmd.
- tx_data is stable from the EXEC cycle until the next EXEC; the transmitter may sample it at the tx_start cycle.
- Latency: CHK byte accepted at cycle N -> EXEC at N+1 -> tx_start at N+2 if tx_busy=0 at N+2. Otherwise tx_start is asserted on the first cycle tx_busy=0.
- Bytes accepted during EXEC or SEND are dropped and increment err_count (overrun).
- Timeout:
  - Active only in GET_CMD, GET_OPR and GET_CHK.
  - The counter clears on every accepted byte and on entering these states.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: -> IDLE, err_count+1, no response.
  - A byte accepted on the terminal cycle wins; no timeout occurs.
- err_count saturates at 8'hFF. Simultaneous error sources in one cycle add 1 total.
- Reset mid-frame or mid-SEND: the frame is abandoned, tx_start=0 at that edge, and no response is sent after reset.

Test Plan:
- Reset then A5,01,05,04 with rx_valid held 3 cycles each -> leds=4'b0101; tx_data=06; one tx_start pulse 2 cycles after the CHK edge; frame_ok=1 once.
- A5,02,FF,FD -> tx_data=00, tx_start once. A5,03,00,03 after the previous SET -> tx_data=05.
- A5,01,05,00 (bad chk) -> tx_data=15, err_count=1, leds unchanged. A5,07,00,07 (unknown cmd) -> tx_data=15, err_count=2.
- tx_busy=1 for 50 cycles during SEND -> tx_start=0 throughout, then one pulse the first cycle tx_busy=0; a byte sent meanwhile -> err_count+1, frame not started.
- TIMEOUT_CYCLES=16: A5,01 then idle 20 cycles -> state IDLE, err_count+1, no tx_start; next A5,01,0A,0B -> leds=4'b1010.
- Stray bytes 00,FF before SYNC -> ignored, err_count unchanged. rst_n=0 for one cycle after A5,01 -> state IDLE, all outputs 0; following 05,04 bytes ignored.
